// File: rtl/mvm_feeder.sv
// Command-driven beat sequencer feeding the MVM array: turns one command into a
// weight-load or calc burst through a single output register, then holds a guard gap.
module mvm_feeder #(
  parameter int IC_N        = 8,
  parameter int WINDOW_SIZE = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int OC_N        = 8,
  parameter int CALC_CYCLES = 8,
  parameter int GAP_CYCLES  = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cmd_valid,
  output logic                                      cmd_ready,
  input  logic                                      cmd_calc,
  input  logic [$clog2(CALC_CYCLES+1)-1:0]          cmd_len,
  input  logic                                      src_valid,
  output logic                                      src_ready,
  input  logic [IC_N*WINDOW_SIZE*DATA_WIDTH-1:0]    src_data,
  input  logic [IC_N-1:0]                           src_strobe,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic                                      load_mode_o,
  output logic [IC_N-1:0]                           strobe_o,
  output logic [IC_N*WINDOW_SIZE*DATA_WIDTH-1:0]    vector_o,
  output logic                                      wts_loaded,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      cmd_err
);

  localparam int CH_W      = WINDOW_SIZE * DATA_WIDTH;
  localparam int LEN_W     = $clog2(CALC_CYCLES + 1);
  localparam int MAX_BEATS = (OC_N > CALC_CYCLES) ? OC_N : CALC_CYCLES;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WLOAD = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] issued_reg;
  logic [CNT_W-1:0] accepted_reg;
  logic [CNT_W-1:0] target_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             burst_calc_reg;
  logic             wts_reg;
  logic             cmd_err_reg;
  logic             valid_reg;
  logic             load_mode_reg;

  logic in_burst;
  logic cmd_accept;
  logic len_ok;
  logic src_accept;
  logic out_accept;
  logic last_accept;
  logic gap_last;

  assign in_burst    = (state_reg == WLOAD) || (state_reg == CALC);
  assign cmd_ready   = (state_reg == IDLE);
  assign cmd_accept  = cmd_valid && cmd_ready;
  assign len_ok      = (cmd_len != '0) && (cmd_len <= LEN_W'(CALC_CYCLES));
  assign src_ready   = in_burst && (issued_reg < target_reg) && (!valid_reg || ready_i);
  assign src_accept  = src_valid && src_ready;
  assign out_accept  = valid_reg && ready_i;
  assign last_accept = out_accept && in_burst && ((accepted_reg + CNT_ONE) == target_reg);
  assign gap_last    = (state_reg == GAP) && (gap_cnt_reg == '0);

  assign busy        = (state_reg != IDLE);
  assign done        = gap_last;
  // Weight-set flag rises in the same cycle as the closing done pulse.
  assign wts_loaded  = wts_reg || (gap_last && !burst_calc_reg);
  assign cmd_err     = cmd_err_reg;
  assign valid_o     = valid_reg;
  assign load_mode_o = load_mode_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      issued_reg     <= '0;
      accepted_reg   <= '0;
      target_reg     <= '0;
      gap_cnt_reg    <= '0;
      burst_calc_reg <= 1'b0;
      wts_reg        <= 1'b0;
      cmd_err_reg    <= 1'b0;
    end else begin
      cmd_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_accept) begin
            issued_reg   <= '0;
            accepted_reg <= '0;
            if (!cmd_calc) begin
              state_reg      <= WLOAD;
              target_reg     <= CNT_W'(OC_N);
              burst_calc_reg <= 1'b0;
              wts_reg        <= 1'b0;
            end else if (wts_reg && len_ok) begin
              state_reg      <= CALC;
              target_reg     <= CNT_W'(cmd_len);
              burst_calc_reg <= 1'b1;
            end else begin
              cmd_err_reg <= 1'b1;
            end
          end
        end
        WLOAD, CALC: begin
          if (src_accept) issued_reg <= issued_reg + CNT_ONE;
          if (out_accept) accepted_reg <= accepted_reg + CNT_ONE;
          if (last_accept) begin
            state_reg   <= GAP;
            gap_cnt_reg <= GAP_W'(GAP_CYCLES - 1);
          end
        end
        default: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= IDLE;
            if (!burst_calc_reg) wts_reg <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
          end
        end
      endcase
    end
  end

  // Output register: a refill on the same edge as a drain keeps valid_o high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      load_mode_reg <= 1'b0;
    end else if (src_accept) begin
      valid_reg     <= 1'b1;
      load_mode_reg <= (state_reg == CALC);
    end else if (out_accept) begin
      valid_reg     <= 1'b0;
      load_mode_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < IC_N; gi++) begin : g_chan
      logic [CH_W-1:0] chan_reg;
      logic            strobe_reg;

      // Payload holds its last value while idle; strobe drops with valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          chan_reg   <= '0;
          strobe_reg <= 1'b0;
        end else if (src_accept) begin
          chan_reg   <= src_data[gi*CH_W +: CH_W];
          strobe_reg <= src_strobe[gi];
        end else if (out_accept) begin
          strobe_reg <= 1'b0;
        end
      end

      assign vector_o[gi*CH_W +: CH_W] = chan_reg;
      assign strobe_o[gi]              = strobe_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mvm_feeder.sv
// Scoreboard bench for mvm_feeder: commands push expected beats, a monitor pops
// and compares on every MVM handshake; timing checked against hand-computed cycles.
module tb_mvm_feeder;

  localparam int VEC_W = 8 * 9 * 8;

  typedef struct {
    logic [VEC_W-1:0] vec;
    logic [7:0]       strb;
    logic             mode;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_calc;
  logic [3:0]       cmd_len;
  logic             src_valid;
  logic             src_ready;
  logic [VEC_W-1:0] src_data;
  logic [7:0]       src_strobe;
  logic             valid_o;
  logic             ready_i;
  logic             load_mode_o;
  logic [7:0]       strobe_o;
  logic [VEC_W-1:0] vector_o;
  logic             wts_loaded;
  logic             busy;
  logic             done;
  logic             cmd_err;

  mvm_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_calc   (cmd_calc),
    .cmd_len    (cmd_len),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .src_strobe (src_strobe),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .load_mode_o(load_mode_o),
    .strobe_o   (strobe_o),
    .vector_o   (vector_o),
    .wts_loaded (wts_loaded),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t            exp_q[$];
  logic [VEC_W-1:0] mem_data [0:255];
  logic [7:0]       mem_strb [0:255];
  int               src_idx = 0;
  int               src_avail = 0;
  int               stall_idx = -1;
  int               stall_rem = 0;
  bit               src_fire;
  bit               rdy_toggle = 0;

  int               beats = 0;
  int               first_valid = 0;
  bit               seen_first = 0;
  int               last_acc = -1000;
  logic [VEC_W-1:0] last_vec = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic vchk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] pat(input int idx);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int b = 0; b < VEC_W / 8; b++) v[b*8 +: 8] = 8'(idx * 37 + b * 5 + 1);
    return v;
  endfunction

  // Source model: offers pre-loaded beats in order, with an optional stall window.
  initial begin
    src_valid  = 1'b0;
    src_data   = '0;
    src_strobe = '0;
    forever begin
      @(negedge clk);
      src_fire = src_valid && src_ready;
      @(posedge clk);
      #1;
      if (src_fire) src_idx++;
      if (src_idx < src_avail && stall_rem > 0 && src_idx == stall_idx) begin
        src_valid = 1'b0;
        stall_rem--;
      end else if (src_idx < src_avail) begin
        src_valid  = 1'b1;
        src_data   = mem_data[src_idx];
        src_strobe = mem_strb[src_idx];
      end else begin
        src_valid = 1'b0;
      end
    end
  end

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_i = rdy_toggle ? ~ready_i : 1'b1;
    end
  end

  // Monitor: compare the presented beat with the scoreboard head every cycle.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (valid_o) begin
      if (!seen_first) begin
        seen_first  = 1'b1;
        first_valid = cyc;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat act=valid_o=1 req=no beat pending (cycle %0d)", cyc);
      end else begin
        e = exp_q[0];
        vchk("vector", vector_o, e.vec);
        chk("strobe", strobe_o, e.strb);
        chk("load_mode", load_mode_o, e.mode);
        if (ready_i) begin
          void'(exp_q.pop_front());
          beats++;
          last_acc = cyc;
          last_vec = e.vec;
          $display("beat %0d mode=%0d strobe=%h cycle=%0d", beats, e.mode, e.strb, cyc);
        end else begin
          chk("src_ready_when_stalled", src_ready, 0);
        end
      end
    end else begin
      chk("idle_strobe", strobe_o, 0);
      chk("idle_load_mode", load_mode_o, 0);
    end
    if (done) chk("done_after_last_accept", cyc - last_acc, 3);
  end

  task automatic queue_beats(input int n, input logic calc);
    beat_t b;
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = src_avail + i;
      mem_data[idx] = pat(idx);
      mem_strb[idx] = calc ? (8'(idx * 29 + 3) | 8'h01) : 8'hFF;
      b.vec  = mem_data[idx];
      b.strb = mem_strb[idx];
      b.mode = calc;
      exp_q.push_back(b);
    end
    src_avail += n;
  endtask

  task automatic send_cmd(input logic calc, input logic [3:0] len, output int c0);
    @(posedge clk);
    #1;
    seen_first = 1'b0;
    beats      = 0;
    cmd_valid  = 1'b1;
    cmd_calc   = calc;
    cmd_len    = len;
    c0         = cyc;
    @(negedge clk);
    chk("cmd_ready_at_offer", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("cmd calc=%0d len=%0d cycle=%0d", calc, len, c0);
  endtask

  task automatic wait_done(output int dc);
    bit got;
    got = 1'b0;
    dc  = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen_within_budget", got, 1);
    dc = cyc;
  endtask

  task automatic bad_cmd(input logic [3:0] len, input logic exp_wts);
    int c;
    send_cmd(1'b1, len, c);
    @(negedge clk);
    chk("cmd_err_pulse", cmd_err, 1);
    chk("busy_after_reject", busy, 0);
    chk("valid_after_reject", valid_o, 0);
    chk("wts_after_reject", wts_loaded, exp_wts);
    @(negedge clk);
    chk("cmd_err_one_cycle", cmd_err, 0);
    chk("cmd_ready_after_reject", cmd_ready, 1);
  endtask

  initial begin
    int c0;
    int dc;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_calc  = 1'b0;
    cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, first cycle after release
    @(negedge clk);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_strobe_o", strobe_o, 0);
    chk("rst_load_mode_o", load_mode_o, 0);
    vchk("rst_vector_o", vector_o, '0);
    chk("rst_wts_loaded", wts_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Calc before any weights are loaded
    bad_cmd(4'd5, 1'b0);

    // Full-rate weight load: valid 2..9, done 12, ready 13
    queue_beats(8, 1'b0);
    send_cmd(1'b0, 4'd0, c0);
    wait_done(dc);
    chk("wl_done_cycle", dc - c0, 12);
    chk("wl_wts_with_done", wts_loaded, 1);
    chk("wl_cmd_ready_in_gap", cmd_ready, 0);
    chk("wl_first_valid", first_valid - c0, 2);
    chk("wl_last_accept", last_acc - c0, 9);
    chk("wl_beats", beats, 8);
    chk("wl_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("wl_cmd_ready_after", cmd_ready, 1);
    chk("wl_done_one_cycle", done, 0);
    chk("wl_wts_held", wts_loaded, 1);
    vchk("wl_vector_holds", vector_o, last_vec);

    // Calc of 5 with ready_i toggling
    queue_beats(5, 1'b1);
    rdy_toggle = 1'b1;
    send_cmd(1'b1, 4'd5, c0);
    wait_done(dc);
    chk("tg_done_gap", dc - last_acc, 3);
    chk("tg_beats", beats, 5);
    chk("tg_queue_empty", exp_q.size(), 0);
    chk("tg_wts_kept", wts_loaded, 1);
    rdy_toggle = 1'b0;
    @(negedge clk);

    // Out-of-range lengths
    bad_cmd(4'd0, 1'b1);
    bad_cmd(4'd9, 1'b1);

    // 8-beat calc with a 2-cycle source stall after beat 3
    stall_idx = src_avail + 3;
    stall_rem = 2;
    queue_beats(8, 1'b1);
    send_cmd(1'b1, 4'd8, c0);
    wait_done(dc);
    chk("st_beats", beats, 8);
    chk("st_first_valid", first_valid - c0, 2);
    chk("st_last_accept", last_acc - c0, 11);
    chk("st_done_cycle", dc - c0, 14);
    chk("st_bubbles", (last_acc - first_valid + 1) - beats, 2);
    chk("st_queue_empty", exp_q.size(), 0);
    @(negedge clk);

    // Reset in cycle 5 of a weight load
    queue_beats(8, 1'b0);
    send_cmd(1'b0, 4'd0, c0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mr_valid_before_rst", valid_o, 1);
    chk("mr_wts_cleared_on_accept", wts_loaded, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mr_valid_o", valid_o, 0);
    chk("mr_wts_loaded", wts_loaded, 0);
    chk("mr_busy", busy, 0);
    chk("mr_strobe_o", strobe_o, 0);
    exp_q.delete();
    src_avail = src_idx;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad_cmd(4'd3, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
